comp_serial: RTL and testbench

COMP_SERIAL -- requirements
Module: comp_serial

---
 rtl/comp_serial_if.sv | 32 +++
 rtl/comp_serial.sv | 126 ++++++++++++
 tb/tb_comp_serial.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/comp_serial_if.sv
// ============================================================================
// Module   : comp_serial_if
// Brief    : Request/result bundle for the bit-serial magnitude comparator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface comp_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             l;
    logic             g;
    logic             e;

    modport master (
        output start, sgn, A, B,
        input  busy, done, l, g, e
    );

    modport slave (
        input  start, sgn, A, B,
        output busy, done, l, g, e
    );
endinterface

`default_nettype wire

// File: rtl/comp_serial.sv
// ============================================================================
// Module   : comp_serial
// Brief    : MSB-first bit-serial comparator, unsigned or two's-complement,
//            terminating on the first differing bit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module comp_serial #(
    parameter int WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    comp_serial_if.slave   bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             l_q, l_d;
    logic             g_q, g_d;
    logic             e_q, e_d;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_sign_pos;

    assign w_a_bit    = a_q[idx_q];
    assign w_b_bit    = b_q[idx_q];
    // In signed mode a set sign bit means the smaller operand.
    assign w_sign_pos = sgn_q && (idx_q == IW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        l_d     = l_q;
        g_d     = g_q;
        e_d     = e_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    sgn_d   = bus.sgn;
                    idx_d   = IW'(WIDTH - 1);
                    l_d     = 1'b0;
                    g_d     = 1'b0;
                    e_d     = 1'b0;
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (w_a_bit != w_b_bit) begin
                    if (w_a_bit ^ w_sign_pos) begin
                        g_d = 1'b1;
                    end else begin
                        l_d = 1'b1;
                    end
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    e_d     = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SCAN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            l_q     <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            l_q     <= l_d;
            g_q     <= g_d;
            e_q     <= e_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.l    = l_q;
    assign bus.g    = g_q;
    assign bus.e    = e_q;
endmodule

`default_nettype wire

// File: tb/tb_comp_serial.sv
// ============================================================================
// Module   : tb_comp_serial
// Brief    : Scoreboarded directed bench for comp_serial (WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_comp_serial;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic [2:0] lge;
        int         cyc;
    } exp_t;

    exp_t q[$];

    comp_serial_if #(.WIDTH(WIDTH)) bus ();

    comp_serial #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest pending entry.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t x;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got lge=%b with no pending request at cycle %0d",
                         {bus.l, bus.g, bus.e}, cyc);
            end else begin
                x = q.pop_front();
                if ({bus.l, bus.g, bus.e} !== x.lge || cyc != x.cyc) begin
                    n_fail++;
                    $display("FAIL result: got lge=%b at cycle %0d expected lge=%b at cycle %0d",
                             {bus.l, bus.g, bus.e}, cyc, x.lge, x.cyc);
                end
            end
        end
    end

    // Entered and left at a negedge; k is the expected latency in edges.
    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [2:0] lge, input int k, input bit disturb);
        bus.A     = a;
        bus.B     = b;
        bus.sgn   = s;
        bus.start = 1'b1;
        q.push_back('{lge, cyc + 1 + k});
        @(negedge clk);
        bus.start = 1'b0;
        for (int j = 0; j < k; j++) begin
            chk("busy_scan", bus.busy, 1'b1);
            if (disturb && j == 2) begin
                bus.A     = 8'hFF;
                bus.start = 1'b1;
            end else if (disturb && j == 3) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("busy_in_done", bus.busy, 1'b0);
        @(negedge clk);
        chk("done_single", bus.done, 1'b0);
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_busy"}, bus.busy, 1'b0);
        chk({name, "_done"}, bus.done, 1'b0);
        chk({name, "_lge"}, |{bus.l, bus.g, bus.e}, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sgn   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        chk_cleared("reset");

        // First start coincides with reset release.
        rst = 1'b0;
        run(8'h05, 8'h03, 1'b0, 3'b010, 6, 1'b0);
        run(8'h5A, 8'h5A, 1'b0, 3'b001, 8, 1'b0);
        run(8'hFF, 8'h01, 1'b0, 3'b010, 1, 1'b0);
        run(8'hFF, 8'h01, 1'b1, 3'b100, 1, 1'b0);
        run(8'h80, 8'h7F, 1'b1, 3'b100, 1, 1'b0);
        run(8'hFE, 8'hFF, 1'b1, 3'b100, 8, 1'b0);
        run(8'h00, 8'hFF, 1'b0, 3'b100, 1, 1'b0);
        run(8'h13, 8'h12, 1'b1, 3'b010, 8, 1'b0);
        // Operand change and extra start during SCAN.
        run(8'h05, 8'h03, 1'b0, 3'b010, 6, 1'b1);

        // Back-to-back with start held through DONE.
        bus.A     = 8'h01;
        bus.B     = 8'h02;
        bus.sgn   = 1'b0;
        bus.start = 1'b1;
        q.push_back('{3'b100, cyc + 1 + 7});
        repeat (8) @(negedge clk);
        chk("b2b_done", bus.done, 1'b1);
        bus.A = 8'h05;
        bus.B = 8'h05;
        q.push_back('{3'b001, cyc + 1 + 8});
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_no_idle", bus.busy, 1'b1);
        repeat (9) @(negedge clk);

        // Reset after a completed compare (A=0, B=0x80) clears the held result.
        bus.A     = 8'h00;
        bus.B     = 8'h80;
        bus.start = 1'b1;
        q.push_back('{3'b100, cyc + 1 + 1});
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_l", bus.l, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_cleared("rst_after_done");

        // Reset in the middle of a long scan: no done may follow.
        bus.A     = 8'h01;
        bus.B     = 8'h00;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_cleared("rst_mid_scan");
        repeat (10) @(negedge clk);

        // Reset coincident with start: start is not accepted.
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        chk("rst_start_busy", bus.busy, 1'b0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("rst_start_idle", bus.busy, 1'b0);

        for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending results expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
